// File: rtl/conv_layer_sched.sv
// conv_layer_sched: walks layer descriptors in SRAM and sequences conv engine start/finish with a watchdog
module conv_layer_sched #(
  parameter int DESC_AW = 8,
  parameter int NUM_ENG = 2,
  parameter int TIMEOUT_W = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic [DESC_AW-1:0] base_addr,
  input  logic [4:0]         num_layers,
  output logic               desc_cs,
  output logic [DESC_AW-1:0] desc_addr,
  input  logic [31:0]        desc_rdata,
  output logic [NUM_ENG-1:0] eng_start,
  output logic [31:0]        eng_w8,
  input  logic [NUM_ENG-1:0] eng_finish,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [4:0]         layer_idx
);
  typedef enum logic [3:0] {IDLE, RD0, RD1, CAP, START, WAIT, NEXT, FIN, ERR} state_t;
  state_t state, state_nxt;
  logic [DESC_AW-1:0] ptr;
  logic [4:0] num_l, layer_inc;
  logic [1:0] id;
  logic [TIMEOUT_W-1:0] wd, wd_inc;
  logic [NUM_ENG-1:0] sel;
  logic bad_id;
  assign layer_inc = layer_idx + 5'd1;
  assign wd_inc = wd + 1'b1;
  assign sel = NUM_ENG'(1) << id;
  assign bad_id = {30'd0, desc_rdata[1:0]} >= 32'(NUM_ENG);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      num_l <= '0;
      layer_idx <= '0;
      id <= '0;
      eng_w8 <= '0;
      wd <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && go) begin
        ptr <= base_addr;
        num_l <= num_layers;
        layer_idx <= '0;
        err <= 1'b0;
      end
      if (state == RD1) id <= desc_rdata[1:0];
      if (state == CAP) eng_w8 <= desc_rdata;
      wd <= (state == WAIT) ? wd_inc : '0;
      if (state == NEXT) begin
        ptr <= ptr + DESC_AW'(2);
        layer_idx <= layer_inc;
      end
      if (state == ERR) err <= 1'b1;
    end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = (num_layers == 5'd0) ? FIN : RD0;
      RD0:     state_nxt = RD1;
      RD1:     state_nxt = bad_id ? ERR : CAP;
      CAP:     state_nxt = START;
      START:   state_nxt = WAIT;
      // a finish coinciding with the final watchdog count still counts as success
      WAIT:    state_nxt = |(eng_finish & sel) ? NEXT : (&wd_inc ? ERR : WAIT);
      NEXT:    state_nxt = (layer_inc == num_l) ? FIN : RD0;
      default: state_nxt = IDLE;
    endcase
  end
  assign desc_cs = (state == RD0) || (state == RD1);
  assign desc_addr = (state == RD0) ? ptr : (state == RD1) ? ptr + DESC_AW'(1) : '0;
  assign eng_start = (state == START) ? sel : '0;
  assign busy = state != IDLE;
  assign done = state == FIN;
endmodule

// File: tb/tb_conv_layer_sched.sv
// tb_conv_layer_sched: scoreboard bench for the layer scheduler with an SRAM and engine model
module tb_conv_layer_sched;
  logic clk = 1'b0, rst = 1'b1, go = 1'b0;
  logic [7:0] base_addr = '0, desc_addr;
  logic [4:0] num_layers = '0, layer_idx;
  logic desc_cs, busy, done, err;
  logic [31:0] desc_rdata = '0, eng_w8;
  logic [1:0] eng_start, eng_finish = '0, fin_sel = '0;
  logic [31:0] mem [256];
  logic [1:0] lay_id [8];
  logic [31:0] lay_w8 [8];
  typedef struct packed {logic [1:0] s; logic [31:0] w; logic [4:0] i;} st_t;
  st_t start_q[$];
  st_t e;
  logic [7:0] addr_q[$];
  int checks = 0, errors = 0, cyc = 0, cnt = 0, fin_dly = 0;
  int cs_cnt = 0, start_cnt = 0, done_cnt = 0, t_start = 0, t_done = 0, t_idle = 0;
  int d0, c0, s0;

  conv_layer_sched #(.DESC_AW(8), .NUM_ENG(2), .TIMEOUT_W(4)) dut (
    .clk(clk), .rst(rst), .go(go), .base_addr(base_addr), .num_layers(num_layers),
    .desc_cs(desc_cs), .desc_addr(desc_addr), .desc_rdata(desc_rdata),
    .eng_start(eng_start), .eng_w8(eng_w8), .eng_finish(eng_finish),
    .busy(busy), .done(done), .err(err), .layer_idx(layer_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (desc_cs) desc_rdata <= mem[desc_addr];

  // engine model: finish pulse fin_dly cycles after the start pulse; silent when fin_dly is 0
  always @(negedge clk) begin
    eng_finish = '0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) eng_finish = fin_sel;
    end
    if (eng_start != '0 && fin_dly > 0) begin
      cnt = fin_dly;
      fin_sel = eng_start;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (desc_cs) begin
      cs_cnt++;
      if (addr_q.size() == 0) chk("cs_unexp", 64'(desc_cs), 0);
      else chk("desc_addr", 64'(desc_addr), 64'(addr_q.pop_front()));
    end
    if (eng_start != '0) begin
      start_cnt++;
      t_start = cyc;
      if (start_q.size() == 0) chk("start_unexp", 64'(eng_start), 0);
      else begin
        e = start_q.pop_front();
        chk("eng_start", 64'(eng_start), 64'(e.s));
        chk("eng_w8", 64'(eng_w8), 64'(e.w));
        chk("layer_idx", 64'(layer_idx), 64'(e.i));
      end
    end
    if (done) begin
      done_cnt++;
      t_done = cyc;
    end
  end

  task automatic load(input logic [7:0] b, input int n, input int k);
    for (int i = 0; i < n; i++) begin
      mem[8'(b + 8'(2 * i))] = {30'h15555555, lay_id[i]};
      mem[8'(b + 8'(2 * i + 1))] = lay_w8[i];
    end
    for (int i = 0; i < k; i++) begin
      addr_q.push_back(8'(b + 8'(2 * i)));
      addr_q.push_back(8'(b + 8'(2 * i + 1)));
      start_q.push_back('{2'b01 << lay_id[i], lay_w8[i], 5'(i)});
    end
  endtask

  task automatic pulse_go(input logic [7:0] b, input logic [4:0] n);
    @(negedge clk);
    base_addr = b;
    num_layers = n;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    t_idle = cyc;
    chk(tag, 64'(busy), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_start", 64'(eng_start), 0);
    chk("rst_cs", 64'(desc_cs), 0);
    chk("rst_addr", 64'(desc_addr), 0);
    chk("rst_idx", 64'(layer_idx), 0);
    chk("rst_w8", 64'(eng_w8), 0);
    rst = 1'b0;

    lay_id[0] = 2'd0; lay_w8[0] = 32'h7F01FF80; fin_dly = 10;
    load(8'h00, 1, 1);
    d0 = done_cnt;
    pulse_go(8'h00, 5'd1);
    wait_idle("t1_idle");
    chk("t1_done_lat", 64'(t_done - t_start), 12);
    chk("t1_done_cnt", 64'(done_cnt - d0), 1);
    chk("t1_w8_hold", 64'(eng_w8), 64'h7F01FF80);
    chk("t1_err", 64'(err), 0);
    chk("t1_idx_final", 64'(layer_idx), 1);

    lay_id[0] = 2'd0; lay_w8[0] = 32'hA5A5_0001;
    lay_id[1] = 2'd1; lay_w8[1] = 32'h8001_7FFF;
    lay_id[2] = 2'd0; lay_w8[2] = 32'h0102_0304;
    fin_dly = 5;
    load(8'h10, 3, 3);
    d0 = done_cnt;
    pulse_go(8'h10, 5'd3);
    repeat (3) @(negedge clk);
    base_addr = 8'h80;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_idle("t2_idle");
    chk("t2_done_cnt", 64'(done_cnt - d0), 1);
    chk("t2_idx_final", 64'(layer_idx), 3);

    d0 = done_cnt; c0 = cs_cnt; s0 = start_cnt;
    pulse_go(8'h20, 5'd0);
    wait_idle("t3_idle");
    chk("t3_done_cnt", 64'(done_cnt - d0), 1);
    chk("t3_cs_cnt", 64'(cs_cnt - c0), 0);
    chk("t3_start_cnt", 64'(start_cnt - s0), 0);

    mem[8'h30] = 32'hFFFF_FFF3;
    addr_q.push_back(8'h30);
    addr_q.push_back(8'h31);
    d0 = done_cnt; s0 = start_cnt;
    pulse_go(8'h30, 5'd1);
    wait_idle("t4_idle");
    chk("t4_err", 64'(err), 1);
    chk("t4_done_cnt", 64'(done_cnt - d0), 0);
    chk("t4_start_cnt", 64'(start_cnt - s0), 0);

    lay_id[0] = 2'd1; lay_w8[0] = 32'hDEAD_BEEF; fin_dly = 0;
    load(8'h40, 1, 1);
    d0 = done_cnt;
    pulse_go(8'h40, 5'd1);
    chk("t5_err_clr", 64'(err), 0);
    wait_idle("t5_idle");
    chk("t5_err", 64'(err), 1);
    chk("t5_to_lat", 64'(t_idle - t_start), 17);
    chk("t5_done_cnt", 64'(done_cnt - d0), 0);
    fin_dly = 15;
    load(8'h40, 1, 1);
    d0 = done_cnt;
    pulse_go(8'h40, 5'd1);
    wait_idle("t5b_idle");
    chk("t5b_err", 64'(err), 0);
    chk("t5b_done_cnt", 64'(done_cnt - d0), 1);

    lay_id[0] = 2'd0; lay_w8[0] = 32'h1111_2222;
    lay_id[1] = 2'd1; lay_w8[1] = 32'h3333_4444;
    lay_id[2] = 2'd0; lay_w8[2] = 32'h5555_6666;
    fin_dly = 8;
    load(8'hFC, 3, 2);
    d0 = done_cnt; s0 = start_cnt;
    pulse_go(8'hFC, 5'd3);
    for (int n = 0; n < 200 && start_cnt < s0 + 2; n++) @(negedge clk);
    chk("t6_reach", 64'(start_cnt - s0), 2);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_busy", 64'(busy), 0);
    chk("t6_rst_idx", 64'(layer_idx), 0);
    chk("t6_rst_w8", 64'(eng_w8), 0);
    chk("t6_rst_start", 64'(eng_start), 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("t6_stay_idle", 64'(busy), 0);
    chk("t6_no_done", 64'(done_cnt - d0), 0);
    chk("t6_no_start", 64'(start_cnt - s0), 2);
    load(8'hFC, 3, 3);
    pulse_go(8'hFC, 5'd3);
    wait_idle("t6_idle");
    chk("t6_done_cnt", 64'(done_cnt - d0), 1);
    chk("t6_starts", 64'(start_cnt - s0), 5);

    chk("addr_q_left", 64'(addr_q.size()), 0);
    chk("start_q_left", 64'(start_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
